// File: rtl/qracc_bitserial_mac.sv
// Bit-serial charge-domain MAC sequencer for a QR-accumulator array.
// Drives one activation bit plane per DRIVE/SAMPLE pair, LSB first. Each column's
// thermometer ADC code is decoded and shift-accumulated, with the MSB plane subtracted
// for two's-complement inputs.
// Optional build macro: QRACC_BUBBLE_CORRECT_EN selects a popcount decode, which
// tolerates thermometer bubbles, instead of the default priority decode.
module qracc_bitserial_mac #(
   parameter int unsigned numRows    = 128,
   parameter int unsigned numCols    = 32,
   parameter int unsigned numAdcBits = 4,
   parameter int unsigned numInBits  = 4
) (
   input  logic                                       clk,
   input  logic                                       nrst,
   input  logic                                       in_valid_i,
   output logic                                       in_ready_o,
   input  logic [numRows*numInBits-1:0]               in_data_i,
   output logic [numRows-1:0]                         drive_p_o,
   output logic                                       mac_en_o,
   input  logic [numCols*((1<<numAdcBits)-1)-1:0]     adc_therm_i,
   output logic                                       out_valid_o,
   input  logic                                       out_ready_i,
   output logic [numCols*(numAdcBits+numInBits)-1:0]  out_data_o
);

   localparam int unsigned compCount = (1 << numAdcBits) - 1;
   localparam int unsigned accBits   = numAdcBits + numInBits;
   localparam int unsigned BitW      = (numInBits > 1) ? $clog2(numInBits) : 1;
   localparam logic [numAdcBits-1:0] SignFlip = numAdcBits'(1 << (numAdcBits - 1));

   typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

   state_e                        state_q;
   logic [numRows*numInBits-1:0]  data_q;
   logic [BitW-1:0]               bit_q;
   logic [BitW-1:0]               bit_sel;
   logic                          last_plane;
   logic [numCols*accBits-1:0]    acc_q;
   logic [numCols*accBits-1:0]    acc_d;
   logic [numCols*accBits-1:0]    out_data_q;
   logic [numRows-1:0]            drive_q;
   logic [numRows-1:0]            plane_first;
   logic [numRows-1:0]            plane_next;
   logic                          ready_q;
   logic                          mac_en_q;
   logic                          out_valid_q;

   assign last_plane = (bit_q == BitW'(numInBits - 1));
   assign bit_sel    = last_plane ? '0 : bit_q + 1'b1;

   // Bit-plane extraction: plane 0 straight from the input, the next plane from latched data.
   always_comb begin
      plane_first = '0;
      plane_next  = '0;
      for (int r = 0; r < int'(numRows); r++) begin
         plane_first[r] = in_data_i[r*numInBits];
         plane_next[r]  = data_q[r*numInBits + int'(bit_sel)];
      end
   end

   for (genvar c = 0; c < numCols; c++) begin : g_col
      logic [compCount-1:0]  therm;
      logic [numAdcBits-1:0] cnt;
      logic [numAdcBits-1:0] dec;
      logic [accBits-1:0]    term;

      assign therm = adc_therm_i[c*compCount +: compCount];

      // Thermometer code to level count (0 .. compCount).
      always_comb begin
         cnt = '0;
         for (int k = 0; k < int'(compCount); k++) begin
`ifdef QRACC_BUBBLE_CORRECT_EN
            cnt = cnt + numAdcBits'(therm[k]);
`else
            if (therm[k]) cnt = numAdcBits'(k + 1);
`endif
         end
      end

      // Subtracting 2^(n-1) from an n-bit count is just an MSB flip.
      assign dec  = cnt ^ SignFlip;
      assign term = {{numInBits{dec[numAdcBits-1]}}, dec} << bit_q;
      assign acc_d[c*accBits +: accBits] = last_plane ? acc_q[c*accBits +: accBits] - term
                                                      : acc_q[c*accBits +: accBits] + term;
   end

   // Sequencer with registered outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= StIdle;
         data_q      <= '0;
         bit_q       <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         drive_q     <= '0;
         ready_q     <= 1'b1;
         mac_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid_i) begin
                  data_q   <= in_data_i;
                  acc_q    <= '0;
                  bit_q    <= '0;
                  drive_q  <= plane_first;
                  mac_en_q <= 1'b1;
                  ready_q  <= 1'b0;
                  state_q  <= StDrive;
               end
            end
            StDrive: begin
               mac_en_q <= 1'b0;
               state_q  <= StSample;
            end
            StSample: begin
               acc_q <= acc_d;
               if (last_plane) begin
                  drive_q <= '0;
                  state_q <= StDone;
               end else begin
                  bit_q    <= bit_q + 1'b1;
                  drive_q  <= plane_next;
                  mac_en_q <= 1'b1;
                  state_q  <= StDrive;
               end
            end
            StDone: begin
               // First DONE cycle publishes the result; later cycles wait for the consumer.
               if (!out_valid_q) begin
                  out_data_q  <= acc_q;
                  out_valid_q <= 1'b1;
               end else if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  ready_q     <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready_o  = ready_q;
   assign drive_p_o   = drive_q;
   assign mac_en_o    = mac_en_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule
